ex_issue_stage: RTL and testbench

//  ID->EX pipeline register for the OSYRYS-64 execute stage; feeds the ALU directly.
//  - Captures decoded ops and selects operands: src1 = rs1|PC, src2 = rs2|imm.
//  - Presents src1, src2 and alu_control registered to the ALU, with a valid/ready handshake.
//  - A 2-entry skid buffer gives full throughput under backpressure; flush discards held ops.

---
 rtl/ex_issue_stage.sv | 187 ++++++++++++++++++
 tb/tb_ex_issue_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_issue_stage.sv
// ---------------------------------------------------------------------------
// ex_issue_stage
//
// ID->EX pipeline register for the OSYRYS-64 execute stage. Decoded ops are
// captured with their ALU operands already selected (src1 = rs1|PC,
// src2 = rs2|imm) and presented, registered, directly to the ALU.
//
// Storage is a main register, which drives the outputs, plus one skid
// register. Together they sustain one op per cycle under backpressure while
// keeping in_ready a pure register output.
//
// Optional feature (compile-time macro OSYRYS_EX_FWD_EN):
//   When defined, a valid writeback result (fwd_*) whose destination matches
//   a source register index replaces that regfile value at capture. x0 is
//   never forwarded, and an operand that selects PC or imm is never
//   forwarded. When undefined, the fwd_* ports are present but ignored.
//
// Handshake: both sides use strict valid/ready. A transfer happens on a
// rising clk edge where valid && ready. A producer holds valid and its
// payload stable until the transfer. The consumer-side payload (src1, src2,
// alu_control, out_rd_addr, out_pc) holds stable while out_valid && !out_ready.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   flush            discard every held op on the next edge
//   in_valid/ready   upstream handshake (in_ready = !skid full)
//   in_pc, in_rs1_data, in_rs2_data, in_imm   operand sources
//   in_rs1_addr, in_rs2_addr                  source indices (forwarding)
//   in_rd_addr, in_src1_sel, in_src2_sel, in_alu_control   decoded op
//   fwd_valid, fwd_rd_addr, fwd_data          writeback bypass
//   out_valid/out_ready                       downstream handshake
//   src1, src2, alu_control, out_rd_addr, out_pc   registered op to ALU
// ---------------------------------------------------------------------------
module ex_issue_stage #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [4:0]        in_rs1_addr,
    input  logic [4:0]        in_rs2_addr,
    input  logic [4:0]        in_rd_addr,
    input  logic              in_src1_sel,
    input  logic              in_src2_sel,
    input  logic [CTRL_W-1:0] in_alu_control,
    input  logic              fwd_valid,
    input  logic [4:0]        fwd_rd_addr,
    input  logic [XLEN-1:0]   fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   src1,
    output logic [XLEN-1:0]   src2,
    output logic [CTRL_W-1:0] alu_control,
    output logic [4:0]        out_rd_addr,
    output logic [XLEN-1:0]   out_pc
);

    // Main register (drives the outputs)
    logic              r_main_valid;
    logic [XLEN-1:0]   r_main_src1;
    logic [XLEN-1:0]   r_main_src2;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [4:0]        r_main_rd;
    logic [XLEN-1:0]   r_main_pc;

    // Skid register (holds an op accepted while main was stalled)
    logic              r_skid_valid;
    logic [XLEN-1:0]   r_skid_src1;
    logic [XLEN-1:0]   r_skid_src2;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [4:0]        r_skid_rd;
    logic [XLEN-1:0]   r_skid_pc;

    logic              w_accept;
    logic              w_drain;
    logic              w_main_free;
    logic [XLEN-1:0]   w_rs1_val;
    logic [XLEN-1:0]   w_rs2_val;
    logic [XLEN-1:0]   w_src1;
    logic [XLEN-1:0]   w_src2;

    // Skid is only ever filled while main is occupied, so "skid empty" is
    // exactly "there is room for one more op" and in_ready needs no logic
    // beyond a register.
    assign in_ready    = !r_skid_valid;
    assign w_accept    = in_valid && in_ready;
    assign w_drain     = r_main_valid && out_ready;
    assign w_main_free = !r_main_valid || w_drain;

`ifdef OSYRYS_EX_FWD_EN
    // Writeback bypass: x0 is hard-wired zero, so it is never forwarded.
    assign w_rs1_val = (fwd_valid && (fwd_rd_addr != 5'd0) && (fwd_rd_addr == in_rs1_addr))
                       ? fwd_data : in_rs1_data;
    assign w_rs2_val = (fwd_valid && (fwd_rd_addr != 5'd0) && (fwd_rd_addr == in_rs2_addr))
                       ? fwd_data : in_rs2_data;
`else
    assign w_rs1_val = in_rs1_data;
    assign w_rs2_val = in_rs2_data;
    // Bypass inputs exist for port compatibility only in this build.
    logic w_unused_fwd;
    assign w_unused_fwd = &{1'b0, fwd_valid, fwd_rd_addr, fwd_data, in_rs1_addr, in_rs2_addr};
`endif

    // Operand mux applied at capture; both registers store selected operands.
    assign w_src1 = in_src1_sel ? in_pc  : w_rs1_val;
    assign w_src2 = in_src2_sel ? in_imm : w_rs2_val;

    // Valid bits: flush wins over any accept or move in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            // With skid full, in_ready is low, so no new op competes with
            // the skid->main move.
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_accept;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
        end
    end

    // Main payload. Payload registers load whenever a slot is filled. A flush
    // may leave stale data behind, which the cleared valid makes harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_src1 <= '0;
            r_main_src2 <= '0;
            r_main_ctrl <= '0;
            r_main_rd   <= '0;
            r_main_pc   <= '0;
        end else if (w_main_free && !flush) begin
            if (r_skid_valid) begin
                r_main_src1 <= r_skid_src1;
                r_main_src2 <= r_skid_src2;
                r_main_ctrl <= r_skid_ctrl;
                r_main_rd   <= r_skid_rd;
                r_main_pc   <= r_skid_pc;
            end else if (w_accept) begin
                r_main_src1 <= w_src1;
                r_main_src2 <= w_src2;
                r_main_ctrl <= in_alu_control;
                r_main_rd   <= in_rd_addr;
                r_main_pc   <= in_pc;
            end
        end
    end

    // Skid payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_src1 <= '0;
            r_skid_src2 <= '0;
            r_skid_ctrl <= '0;
            r_skid_rd   <= '0;
            r_skid_pc   <= '0;
        end else if (!w_main_free && w_accept && !flush) begin
            r_skid_src1 <= w_src1;
            r_skid_src2 <= w_src2;
            r_skid_ctrl <= in_alu_control;
            r_skid_rd   <= in_rd_addr;
            r_skid_pc   <= in_pc;
        end
    end

    assign out_valid   = r_main_valid;
    assign src1        = r_main_src1;
    assign src2        = r_main_src2;
    assign alu_control = r_main_ctrl;
    assign out_rd_addr = r_main_rd;
    assign out_pc      = r_main_pc;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for ex_issue_stage. Inputs change 1 ns after a rising edge.
// Outputs are checked at the same point, so each check sees the state left by
// the preceding edge.
module tb_ex_issue_stage;

    localparam int XLEN   = 64;
    localparam int CTRL_W = 8;
    localparam logic [CTRL_W-1:0] ALU_ADDW = 8'h05;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 8'h02;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_rs1_data;
    logic [XLEN-1:0]   in_rs2_data;
    logic [XLEN-1:0]   in_imm;
    logic [4:0]        in_rs1_addr;
    logic [4:0]        in_rs2_addr;
    logic [4:0]        in_rd_addr;
    logic              in_src1_sel;
    logic              in_src2_sel;
    logic [CTRL_W-1:0] in_alu_control;
    logic              fwd_valid;
    logic [4:0]        fwd_rd_addr;
    logic [XLEN-1:0]   fwd_data;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;
    logic [CTRL_W-1:0] alu_control;
    logic [4:0]        out_rd_addr;
    logic [XLEN-1:0]   out_pc;

    int n_checks = 0;
    int n_pass   = 0;

    ex_issue_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_rs1_data    (in_rs1_data),
        .in_rs2_data    (in_rs2_data),
        .in_imm         (in_imm),
        .in_rs1_addr    (in_rs1_addr),
        .in_rs2_addr    (in_rs2_addr),
        .in_rd_addr     (in_rd_addr),
        .in_src1_sel    (in_src1_sel),
        .in_src2_sel    (in_src2_sel),
        .in_alu_control (in_alu_control),
        .fwd_valid      (fwd_valid),
        .fwd_rd_addr    (fwd_rd_addr),
        .fwd_data       (fwd_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .src1           (src1),
        .src2           (src2),
        .alu_control    (alu_control),
        .out_rd_addr    (out_rd_addr),
        .out_pc         (out_pc)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] rs1,
                            input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] imm,
                            input logic s1, input logic s2,
                            input logic [CTRL_W-1:0] ctrl, input logic [4:0] rd);
        in_valid       = 1'b1;
        in_pc          = pc;
        in_rs1_data    = rs1;
        in_rs2_data    = rs2;
        in_imm         = imm;
        in_src1_sel    = s1;
        in_src2_sel    = s2;
        in_alu_control = ctrl;
        in_rd_addr     = rd;
    endtask

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    logic [XLEN-1:0] exp_fwd_src1;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
        in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
        in_src1_sel = 1'b0; in_src2_sel = 1'b0; in_alu_control = '0;
        fwd_valid = 1'b0; fwd_rd_addr = '0; fwd_data = '0;
        tick(); tick();

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_src1",      src1,           64'd0);
        check("rst_src2",      src2,           64'd0);
        check("rst_ctrl",      64'(alu_control), 64'd0);
        check("rst_rd",        64'(out_rd_addr), 64'd0);
        check("rst_pc",        out_pc,         64'd0);

        rst_n = 1'b1;
        tick();

        // Register operands, one-cycle latency
        out_ready = 1'b1;
        drive_op(64'h100, 64'd5, 64'd7, 64'h9, 1'b0, 1'b0, ALU_ADDW, 5'd1);
        tick();
        in_valid = 1'b0;
        check("op1_valid", 64'(out_valid), 64'd1);
        check("op1_src1",  src1, 64'd5);
        check("op1_src2",  src2, 64'd7);
        check("op1_ctrl",  64'(alu_control), 64'(ALU_ADDW));
        check("op1_rd",    64'(out_rd_addr), 64'd1);
        check("op1_pc",    out_pc, 64'h100);

        // PC / immediate selection
        drive_op(64'h1000, 64'h55, 64'h66, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, ALU_SUB, 5'd2);
        tick();
        in_valid = 1'b0;
        check("op2_valid", 64'(out_valid), 64'd1);
        check("op2_src1",  src1, 64'h1000);
        check("op2_src2",  src2, 64'hFFFF_FFFF_FFFF_FFFC);
        check("op2_ctrl",  64'(alu_control), 64'(ALU_SUB));
        tick();
        check("op2_drained", 64'(out_valid), 64'd0);

        // Backpressure: A to main, B to skid, C ignored while in_ready=0
        out_ready = 1'b0;
        drive_op(64'h200, 64'hA1, 64'hA2, 64'h0, 1'b0, 1'b0, ALU_ADDW, 5'd10);
        tick();
        check("bp_ready_after_a", 64'(in_ready), 64'd1);
        drive_op(64'h204, 64'hB1, 64'hB2, 64'h0, 1'b0, 1'b0, ALU_SUB, 5'd11);
        tick();
        check("bp_ready_after_b", 64'(in_ready), 64'd0);
        check("bp_hold_src1",     src1, 64'hA1);
        drive_op(64'h208, 64'hC1, 64'hC2, 64'h0, 1'b0, 1'b0, ALU_SUB, 5'd12);
        tick();
        in_valid = 1'b0;
        check("bp_still_a_src1", src1, 64'hA1);
        check("bp_still_a_rd",   64'(out_rd_addr), 64'd10);
        check("bp_still_full",   64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        check("bp_b_valid", 64'(out_valid), 64'd1);
        check("bp_b_src1",  src1, 64'hB1);
        check("bp_b_rd",    64'(out_rd_addr), 64'd11);
        check("bp_b_pc",    out_pc, 64'h204);
        check("bp_ready_again", 64'(in_ready), 64'd1);
        tick();
        check("bp_c_not_emitted", 64'(out_valid), 64'd0);

        // Flush with skid full and in_valid high
        out_ready = 1'b0;
        drive_op(64'h300, 64'hD1, 64'h0, 64'h0, 1'b0, 1'b0, ALU_ADDW, 5'd13);
        tick();
        drive_op(64'h304, 64'hE1, 64'h0, 64'h0, 1'b0, 1'b0, ALU_ADDW, 5'd14);
        tick();
        check("fl_full", 64'(in_ready), 64'd0);
        drive_op(64'h308, 64'hF1, 64'h0, 64'h0, 1'b0, 1'b0, ALU_ADDW, 5'd15);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        tick();
        check("fl_nothing_emitted", 64'(out_valid), 64'd0);

        // Flush beats a simultaneous accept into an empty stage
        drive_op(64'h400, 64'h61, 64'h0, 64'h0, 1'b0, 1'b0, ALU_ADDW, 5'd16);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_accept_dropped", 64'(out_valid), 64'd0);
        check("fl_accept_ready",   64'(in_ready),  64'd1);

        // Forwarding (back-to-back ops with out_ready=1)
`ifdef OSYRYS_EX_FWD_EN
        exp_fwd_src1 = 64'hAB;
`else
        exp_fwd_src1 = 64'h11;
`endif
        drive_op(64'h500, 64'h11, 64'h22, 64'h0, 1'b0, 1'b0, ALU_ADDW, 5'd5);
        in_rs1_addr = 5'd3; in_rs2_addr = 5'd4;
        fwd_valid = 1'b1; fwd_rd_addr = 5'd3; fwd_data = 64'hAB;
        tick();
        check("fwd_src1_match", src1, exp_fwd_src1);
        check("fwd_src2_nomatch", src2, 64'h22);
        drive_op(64'h504, 64'h11, 64'h22, 64'h0, 1'b0, 1'b0, ALU_ADDW, 5'd6);
        in_rs1_addr = 5'd0; fwd_rd_addr = 5'd0;
        tick();
        check("fwd_x0_not_forwarded", src1, 64'h11);
        check("fwd_back_to_back_pc",  out_pc, 64'h504);
        drive_op(64'h508, 64'h11, 64'h22, 64'h77, 1'b0, 1'b1, ALU_ADDW, 5'd7);
        in_rs1_addr = 5'd9; in_rs2_addr = 5'd3; fwd_rd_addr = 5'd3;
        tick();
        in_valid = 1'b0; fwd_valid = 1'b0;
        check("fwd_imm_sel_kept", src2, 64'h77);
        check("fwd_src1_other",   src1, 64'h11);
        tick();

        // Asynchronous reset with main and skid occupied
        out_ready = 1'b0;
        drive_op(64'h600, 64'h71, 64'h0, 64'h0, 1'b0, 1'b0, ALU_ADDW, 5'd20);
        tick();
        drive_op(64'h604, 64'h72, 64'h0, 64'h0, 1'b0, 1'b0, ALU_ADDW, 5'd21);
        tick();
        in_valid = 1'b0;
        check("ar_full", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid_now", 64'(out_valid), 64'd0);
        check("ar_src1_now",      src1, 64'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("ar_in_ready_after", 64'(in_ready),  64'd1);
        check("ar_no_op_after",    64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
